// File: rtl/gt_tx_manual_phase_align_multi.sv
// Multi-lane GTX TX buffer-bypass manual phase alignment sequencer.
// Runs DLYSRESET -> PHINIT -> master/slave PHALIGN/DLYEN from one stable clock, with a per-step watchdog.
module gt_tx_manual_phase_align_multi #(
  parameter int NUM_LANES      = 4,
  parameter int MASTER_LANE    = 0,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                 stable_clk_i,
  input  logic                 rst_i,
  input  logic                 run_phalignment_i,
  output logic [NUM_LANES-1:0] txdlysreset_o,
  input  logic [NUM_LANES-1:0] txdlysresetdone_i,
  output logic [NUM_LANES-1:0] txphinit_o,
  input  logic [NUM_LANES-1:0] txphinitdone_i,
  output logic [NUM_LANES-1:0] txphalign_o,
  input  logic [NUM_LANES-1:0] txphaligndone_i,
  output logic [NUM_LANES-1:0] txdlyen_o,
  output logic                 phase_alignment_done_o,
  output logic                 phase_alignment_err_o,
  output logic [3:0]           state_o
);

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    DLYSRST  = 4'd1,
    PHINIT   = 4'd2,
    M_ALIGN  = 4'd3,
    M_DLYEN1 = 4'd4,
    S_ALIGN  = 4'd5,
    M_DLYEN2 = 4'd6,
    DONE     = 4'd7,
    FAIL     = 4'd8
  } state_t;

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TIMER_MAX  = TW'(TIMEOUT_CYCLES);
  localparam logic [NUM_LANES-1:0] ALL_LANES   = '1;
  localparam logic [NUM_LANES-1:0] MASTER_MASK = NUM_LANES'(1) << MASTER_LANE;
  localparam logic [NUM_LANES-1:0] SLAVE_MASK  = ALL_LANES & ~MASTER_MASK;

  // Index 0 = dlysresetdone, 1 = phinitdone, 2 = phaligndone.
  logic [2:0][NUM_LANES-1:0] done_meta, done_sync, done_prev, done_edge;

  state_t               state, state_next;
  logic [NUM_LANES-1:0] seen, seen_next, awaited, lane_edge;
  logic [TW-1:0]        timer;
  logic                 step_done, timed_out, holding;
  logic [NUM_LANES-1:0] dlysreset_d, phinit_d, phalign_d, dlyen_d;

  always_ff @(posedge stable_clk_i or posedge rst_i) begin
    if (rst_i) begin
      done_meta <= '0;
      done_sync <= '0;
      done_prev <= '0;
    end else begin
      done_meta <= {txphaligndone_i, txphinitdone_i, txdlysresetdone_i};
      done_sync <= done_meta;
      done_prev <= done_sync;
    end
  end

  assign done_edge = done_sync & ~done_prev;

  always_comb begin
    awaited   = '0;
    lane_edge = '0;
    case (state)
      DLYSRST: begin
        awaited   = ALL_LANES;
        lane_edge = done_edge[0];
      end
      PHINIT: begin
        awaited   = ALL_LANES;
        lane_edge = done_edge[1];
      end
      M_ALIGN, M_DLYEN1, M_DLYEN2: begin
        awaited   = MASTER_MASK;
        lane_edge = done_edge[2];
      end
      S_ALIGN: begin
        awaited   = SLAVE_MASK;
        lane_edge = done_edge[2];
      end
      default: ;
    endcase

    seen_next = seen | (lane_edge & awaited);
    step_done = (awaited != '0) && ((seen_next & awaited) == awaited);
    // Completion is tested before the watchdog so a last edge landing on the timeout cycle still advances.
    timed_out = (awaited != '0) && (timer >= TIMER_LAST);

    state_next = state;
    if (!run_phalignment_i) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:     state_next = DLYSRST;
        DLYSRST:  if (step_done) state_next = PHINIT;   else if (timed_out) state_next = FAIL;
        PHINIT:   if (step_done) state_next = M_ALIGN;  else if (timed_out) state_next = FAIL;
        M_ALIGN:  if (step_done) state_next = M_DLYEN1; else if (timed_out) state_next = FAIL;
        M_DLYEN1: if (step_done) state_next = (NUM_LANES == 1) ? DONE : S_ALIGN;
                  else if (timed_out) state_next = FAIL;
        S_ALIGN:  if (step_done) state_next = M_DLYEN2; else if (timed_out) state_next = FAIL;
        M_DLYEN2: if (step_done) state_next = DONE;     else if (timed_out) state_next = FAIL;
        default:  state_next = state;
      endcase
    end

    // Controls drop on the transition edge and rise a cycle later, leaving a one-cycle gap between steps.
    holding     = (state_next == state);
    dlysreset_d = (holding && state == DLYSRST) ? ALL_LANES : '0;
    phinit_d    = (holding && state == PHINIT) ? ALL_LANES : '0;
    phalign_d   = !holding ? '0 :
                  (state == M_ALIGN) ? MASTER_MASK :
                  (state == S_ALIGN) ? SLAVE_MASK : '0;
    dlyen_d     = (holding && (state == M_DLYEN1 || state == M_DLYEN2)) ? MASTER_MASK : '0;
  end

  always_ff @(posedge stable_clk_i or posedge rst_i) begin
    if (rst_i) begin
      state                  <= IDLE;
      seen                   <= '0;
      timer                  <= '0;
      txdlysreset_o          <= '0;
      txphinit_o             <= '0;
      txphalign_o            <= '0;
      txdlyen_o              <= '0;
      phase_alignment_done_o <= 1'b0;
      phase_alignment_err_o  <= 1'b0;
    end else begin
      state <= state_next;
      if (!holding) begin
        seen  <= '0;
        timer <= '0;
      end else begin
        seen <= seen_next;
        if (awaited != '0 && timer != TIMER_MAX) timer <= timer + 1'b1;
      end
      txdlysreset_o          <= dlysreset_d;
      txphinit_o             <= phinit_d;
      txphalign_o            <= phalign_d;
      txdlyen_o              <= dlyen_d;
      phase_alignment_done_o <= (state_next == DONE);
      phase_alignment_err_o  <= (state_next == FAIL);
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_gt_tx_manual_phase_align_multi.sv
// Directed bench for gt_tx_manual_phase_align_multi: 4-lane and 1-lane sequences,
// watchdog, held-done, abort and mid-sequence reset cases.
module tb_gt_tx_manual_phase_align_multi;

  localparam int TIMEOUT = 100;

  logic       clk = 1'b0;
  logic       rst;
  logic       run4, run1;
  logic [3:0] dlys4, phinit4, phal4;
  logic [3:0] dlysreset4, phinitout4, phalignout4, dlyen4, state4;
  logic       done4, err4;
  logic [0:0] dlys1, phinit1, phal1;
  logic [0:0] dlysreset1, phinitout1, phalignout1, dlyen1;
  logic [3:0] state1;
  logic       done1, err1;
  logic [15:0] lanes4;

  int vectors = 0;
  int miscompares = 0;
  bit dlyen_bad = 1'b0;
  bit overlap_bad = 1'b0;
  bit slave_state_seen1 = 1'b0;

  always #5 clk = ~clk;

  assign lanes4 = {dlysreset4, phinitout4, phalignout4, dlyen4};

  gt_tx_manual_phase_align_multi #(
    .NUM_LANES(4), .MASTER_LANE(0), .TIMEOUT_CYCLES(TIMEOUT)
  ) dut4 (
    .stable_clk_i          (clk),
    .rst_i                 (rst),
    .run_phalignment_i     (run4),
    .txdlysreset_o         (dlysreset4),
    .txdlysresetdone_i     (dlys4),
    .txphinit_o            (phinitout4),
    .txphinitdone_i        (phinit4),
    .txphalign_o           (phalignout4),
    .txphaligndone_i       (phal4),
    .txdlyen_o             (dlyen4),
    .phase_alignment_done_o(done4),
    .phase_alignment_err_o (err4),
    .state_o               (state4)
  );

  gt_tx_manual_phase_align_multi #(
    .NUM_LANES(1), .MASTER_LANE(0), .TIMEOUT_CYCLES(TIMEOUT)
  ) dut1 (
    .stable_clk_i          (clk),
    .rst_i                 (rst),
    .run_phalignment_i     (run1),
    .txdlysreset_o         (dlysreset1),
    .txdlysresetdone_i     (dlys1),
    .txphinit_o            (phinitout1),
    .txphinitdone_i        (phinit1),
    .txphalign_o           (phalignout1),
    .txphaligndone_i       (phal1),
    .txdlyen_o             (dlyen1),
    .phase_alignment_done_o(done1),
    .phase_alignment_err_o (err1),
    .state_o               (state1)
  );

  // Sticky watchers for properties that must hold on every cycle.
  always @(negedge clk) begin
    if (dlyen4 != 4'b0000 && dlyen4 != 4'b0001) dlyen_bad = 1'b1;
    if ($countones({|dlysreset4, |phinitout4, |phalignout4, |dlyen4}) > 1) overlap_bad = 1'b1;
    if (state1 == 4'd5 || state1 == 4'd6) slave_state_seen1 = 1'b1;
  end

  function automatic logic [15:0] expLanes(input logic [3:0] s);
    case (s)
      4'd1:    return 16'hF000;
      4'd2:    return 16'h0F00;
      4'd3:    return 16'h0010;
      4'd4:    return 16'h0001;
      4'd5:    return 16'h00E0;
      4'd6:    return 16'h0001;
      default: return 16'h0000;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int kind, input logic [3:0] lanes, input int delay);
    repeat (delay) @(negedge clk);
    if (kind == 0)      dlys4   = dlys4 | lanes;
    else if (kind == 1) phinit4 = phinit4 | lanes;
    else                phal4   = phal4 | lanes;
  endtask

  task automatic clearInputs();
    dlys4   = 4'b0000;
    phinit4 = 4'b0000;
    phal4   = 4'b0000;
    repeat (4) @(negedge clk);
  endtask

  task automatic waitState(input bit one, input logic [3:0] target, input int budget, input string tag);
    int n = 0;
    while ((one ? state1 : state4) !== target && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput(tag, 32'(one ? state1 : state4), 32'(target));
  endtask

  task automatic driveLanes(input int kind, input logic [3:0] cur);
    applyStimulus(kind, 4'b0001, 10);
    applyStimulus(kind, 4'b0010, 5);
    applyStimulus(kind, 4'b0100, 12);
    repeat (4) @(negedge clk);
    checkOutput($sformatf("hold_s%0d", cur), 32'(state4), 32'(cur));
    applyStimulus(kind, 4'b1000, 4);
  endtask

  task automatic advance(input logic [3:0] target);
    case (target)
      4'd2: driveLanes(0, 4'd1);
      4'd3: driveLanes(1, 4'd2);
      4'd4: applyStimulus(2, 4'b0001, 15);
      4'd5: begin
        phal4[0] = 1'b0;
        applyStimulus(2, 4'b0001, 20);
      end
      4'd6: begin
        phal4 = 4'b0000;
        applyStimulus(2, 4'b0010, 10);
        applyStimulus(2, 4'b0100, 10);
        repeat (4) @(negedge clk);
        checkOutput("hold_s5", 32'(state4), 32'd5);
        applyStimulus(2, 4'b1000, 6);
      end
      default: applyStimulus(2, 4'b0001, 12);
    endcase
    waitState(1'b0, target, 60, $sformatf("enter_s%0d", target));
    checkOutput($sformatf("gap_s%0d", target), 32'(lanes4), 32'd0);
    @(negedge clk);
    checkOutput($sformatf("lanes_s%0d", target), 32'(lanes4), 32'(expLanes(target)));
  endtask

  task automatic startRun();
    run4 = 1'b1;
    waitState(1'b0, 4'd1, 5, "start_s1");
    checkOutput("gap_s1", 32'(lanes4), 32'd0);
    @(negedge clk);
    checkOutput("lanes_s1", 32'(lanes4), 32'(expLanes(4'd1)));
  endtask

  initial begin
    int n;
    rst = 1'b1; run4 = 1'b0; run1 = 1'b0;
    dlys4 = '0; phinit4 = '0; phal4 = '0;
    dlys1 = '0; phinit1 = '0; phal1 = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst_lanes", 32'(lanes4), 32'd0);
    checkOutput("rst_state", 32'(state4), 32'd0);
    checkOutput("rst_done", 32'(done4), 32'd0);
    checkOutput("rst_err", 32'(err4), 32'd0);
    checkOutput("rst_state1", 32'(state1), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Full 4-lane sequence with staggered per-lane responses.
    startRun();
    for (int s = 2; s <= 7; s++) advance(4'(s));
    checkOutput("done_set", 32'(done4), 32'd1);
    repeat (10) @(negedge clk);
    checkOutput("done_sticky", 32'(done4), 32'd1);
    checkOutput("done_state", 32'(state4), 32'd7);
    checkOutput("dlyen_master_only", 32'(dlyen_bad), 32'd0);
    checkOutput("no_overlap", 32'(overlap_bad), 32'd0);

    // Abort from DONE, then abort from S_ALIGN, then a complete rerun.
    run4 = 1'b0;
    @(negedge clk);
    checkOutput("abort_done_state", 32'(state4), 32'd0);
    checkOutput("abort_done_flag", 32'(done4), 32'd0);
    clearInputs();
    startRun();
    for (int s = 2; s <= 5; s++) advance(4'(s));
    run4 = 1'b0;
    @(negedge clk);
    checkOutput("abort_salign_state", 32'(state4), 32'd0);
    checkOutput("abort_salign_lanes", 32'(lanes4), 32'd0);
    clearInputs();
    startRun();
    for (int s = 2; s <= 7; s++) advance(4'(s));
    checkOutput("rerun_done", 32'(done4), 32'd1);

    // Master phaligndone already high before M_ALIGN must not count as an edge.
    run4 = 1'b0;
    @(negedge clk);
    clearInputs();
    startRun();
    advance(4'd2);
    phal4[0] = 1'b1;
    advance(4'd3);
    repeat (30) @(negedge clk);
    checkOutput("held_done_no_advance", 32'(state4), 32'd3);
    phal4[0] = 1'b0;
    repeat (3) @(negedge clk);
    phal4[0] = 1'b1;
    waitState(1'b0, 4'd4, 10, "fresh_edge_advance");
    @(negedge clk);
    checkOutput("m_dlyen1_lanes", 32'(lanes4), 32'h0001);

    // Asynchronous reset in M_DLYEN1.
    #2 rst = 1'b1;
    #1;
    checkOutput("async_rst_lanes", 32'(lanes4), 32'd0);
    checkOutput("async_rst_state", 32'(state4), 32'd0);
    run4 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("idle_after_rst", 32'(state4), 32'd0);

    // Lane 2 phinitdone withheld: watchdog fires after exactly TIMEOUT cycles in PHINIT.
    clearInputs();
    startRun();
    advance(4'd2);
    applyStimulus(1, 4'b1011, 4);
    n = 5;
    while (state4 == 4'd2 && n < 300) begin
      n++;
      @(negedge clk);
    end
    checkOutput("timeout_cycles", 32'(n), 32'(TIMEOUT));
    checkOutput("timeout_state", 32'(state4), 32'd8);
    checkOutput("timeout_err", 32'(err4), 32'd1);
    checkOutput("timeout_lanes", 32'(lanes4), 32'd0);
    repeat (5) @(negedge clk);
    checkOutput("err_sticky", 32'(err4), 32'd1);
    run4 = 1'b0;
    @(negedge clk);
    checkOutput("fail_abort_state", 32'(state4), 32'd0);
    checkOutput("fail_abort_err", 32'(err4), 32'd0);

    // Last lane edge lands on the timeout cycle: completion takes priority.
    clearInputs();
    startRun();
    advance(4'd2);
    applyStimulus(1, 4'b1011, 4);
    applyStimulus(1, 4'b0100, 92);
    waitState(1'b0, 4'd3, 10, "edge_beats_timeout");
    checkOutput("edge_beats_timeout_err", 32'(err4), 32'd0);
    run4 = 1'b0;

    // Single-lane instance skips the slave steps.
    run1 = 1'b1;
    waitState(1'b1, 4'd1, 5, "one_s1");
    repeat (10) @(negedge clk);
    dlys1 = 1'b1;
    waitState(1'b1, 4'd2, 10, "one_s2");
    repeat (10) @(negedge clk);
    phinit1 = 1'b1;
    waitState(1'b1, 4'd3, 10, "one_s3");
    repeat (10) @(negedge clk);
    phal1 = 1'b1;
    waitState(1'b1, 4'd4, 10, "one_s4");
    phal1 = 1'b0;
    repeat (10) @(negedge clk);
    phal1 = 1'b1;
    waitState(1'b1, 4'd7, 10, "one_done_state");
    checkOutput("one_done_flag", 32'(done1), 32'd1);
    checkOutput("one_no_slave_states", 32'(slave_state_seen1), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
